sum_stream_encoder: RTL



---
 rtl/stoch_util_pkg.sv | 14 +
 rtl/sum_stream_encoder_sat_accumulator.sv | 32 +++
 rtl/sum_stream_encoder.sv | 110 +++++++++++
 3 files changed

// File: rtl/stoch_util_pkg.sv
// Shared constants and helpers for stochastic-computing datapath blocks.
package stoch_util_pkg;

    localparam int SUM_WIDTH_DEF   = 3;
    localparam int COUNT_WIDTH_DEF = 6;
    localparam int DROP_WIDTH_DEF  = 16;

    // Largest value representable in an unsigned field of the given width,
    // i.e. the largest sum an adder tree with that output width can produce.
    function automatic int max_sum(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/sum_stream_encoder_sat_accumulator.sv
// Saturating accumulator: o_sum = min(i_a + i_b - i_dec, all-ones),
// o_excess = amount lost to clamping (zero when no clamp).
// The caller guarantees i_dec is only set when i_a + i_b is non-zero,
// and that B_WIDTH <= WIDTH so the excess always fits in B_WIDTH bits.
module sat_accumulator
    import stoch_util_pkg::*;
#(
    parameter int WIDTH   = COUNT_WIDTH_DEF,
    parameter int B_WIDTH = SUM_WIDTH_DEF
) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic [B_WIDTH-1:0] i_b,
    input  logic               i_dec,
    output logic [WIDTH-1:0]   o_sum,
    output logic [B_WIDTH-1:0] o_excess
);

    localparam logic [WIDTH:0] MAX_VAL = (WIDTH + 1)'(max_sum(WIDTH));

    logic [WIDTH:0] w_raw;
    logic           w_clamp;

    // Add with one spare bit so the true result never wraps, then clamp.
    always_comb begin
        w_raw    = {1'b0, i_a} + {{(WIDTH + 1 - B_WIDTH){1'b0}}, i_b}
                 - {{WIDTH{1'b0}}, i_dec};
        w_clamp  = (w_raw > MAX_VAL);
        o_sum    = w_clamp ? MAX_VAL[WIDTH-1:0] : w_raw[WIDTH-1:0];
        o_excess = w_clamp ? B_WIDTH'(w_raw - MAX_VAL) : '0;
    end

endmodule

// File: rtl/sum_stream_encoder.sv
// Converts a per-cycle multi-bit count back into a unipolar stochastic
// bitstream. A saturating residue counter absorbs each incoming sum and
// releases at most one '1' per cycle; ones that do not fit are counted.
module sum_stream_encoder
    import stoch_util_pkg::*;
#(
    parameter int SUM_WIDTH   = SUM_WIDTH_DEF,
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEF,  // must be >= SUM_WIDTH
    parameter int DROP_WIDTH  = DROP_WIDTH_DEF    // must be >= SUM_WIDTH
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   en,
    input  logic                   clear,
    input  logic [SUM_WIDTH-1:0]   sum,
    output logic                   bit_out,
    output logic [COUNT_WIDTH-1:0] residue,
    output logic                   saturated,
    output logic [DROP_WIDTH-1:0]  drop_count
);

    logic                   r_bit;
    logic [COUNT_WIDTH-1:0] r_residue;
    logic                   r_saturated;
    logic [DROP_WIDTH-1:0]  r_drop;

    logic                   w_emit;
    logic [COUNT_WIDTH-1:0] w_res_sum;
    logic [SUM_WIDTH-1:0]   w_res_excess;
    logic [DROP_WIDTH-1:0]  w_drop_sum;
    logic [SUM_WIDTH-1:0]   w_drop_unused_excess;

    logic                   w_bit_nxt;
    logic [COUNT_WIDTH-1:0] w_residue_nxt;
    logic                   w_saturated_nxt;
    logic [DROP_WIDTH-1:0]  w_drop_nxt;

    // A one is emitted whenever residue + sum is non-zero.
    assign w_emit = (r_residue != '0) || (sum != '0);

    // residue + sum - emit, clamped to the counter range.
    sat_accumulator #(
        .WIDTH   (COUNT_WIDTH),
        .B_WIDTH (SUM_WIDTH)
    ) u_residue_acc (
        .i_a      (r_residue),
        .i_b      (sum),
        .i_dec    (w_emit),
        .o_sum    (w_res_sum),
        .o_excess (w_res_excess)
    );

    // drop_count + clamped excess, itself saturating at all-ones. Its own
    // excess is meaningless once the statistic is pinned, so it is dropped.
    sat_accumulator #(
        .WIDTH   (DROP_WIDTH),
        .B_WIDTH (SUM_WIDTH)
    ) u_drop_acc (
        .i_a      (r_drop),
        .i_b      (w_res_excess),
        .i_dec    (1'b0),
        .o_sum    (w_drop_sum),
        .o_excess (w_drop_unused_excess)
    );

    // Next-state selection: clear beats enable; disabled cycles hold state.
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path leaves it unassigned, which would otherwise infer a latch.
        w_bit_nxt       = 1'b0;
        w_residue_nxt   = r_residue;
        w_saturated_nxt = r_saturated;
        w_drop_nxt      = r_drop;
        if (clear) begin
            w_residue_nxt   = '0;
            w_saturated_nxt = 1'b0;
            w_drop_nxt      = '0;
        end else if (en) begin
            w_bit_nxt     = w_emit;
            w_residue_nxt = w_res_sum;
            w_drop_nxt    = w_drop_sum;
            if (w_res_excess != '0) begin
                w_saturated_nxt = 1'b1;
            end
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_bit       <= 1'b0;
            r_residue   <= '0;
            r_saturated <= 1'b0;
            r_drop      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_bit       <= w_bit_nxt;
            r_residue   <= w_residue_nxt;
            r_saturated <= w_saturated_nxt;
            r_drop      <= w_drop_nxt;
        end
    end

    assign bit_out    = r_bit;
    assign residue    = r_residue;
    assign saturated  = r_saturated;
    assign drop_count = r_drop;

endmodule
